// File: rtl/alu_exec_stage.sv
// Registered MIPS32 execute stage with iterative shifter and valid/ready handshake.
// Optional signed-overflow flag is built when ALU_EXEC_OVF_EN is defined.
module alu_exec_stage #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_alu_control,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [4:0]        i_shamt,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_result,
    output logic              o_branch_taken,
    output logic              o_illegal,
    output logic              o_ovf
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] work;
    logic              shl;
    logic              sar;

    logic              illegal;
    logic              is_shift;
    logic              multi;
    logic              accept;
    logic              out_free;
    logic              load_now;
    logic              load_shift;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] step_val;
    logic              taken;

    assign illegal  = (^i_alu_control === 1'bx);
    assign is_shift = !illegal && (i_alu_control == 4'b0111 ||
                                   i_alu_control == 4'b1000 ||
                                   i_alu_control == 4'b1001);
    assign multi    = is_shift && (i_shamt != 5'd0);

    assign out_free   = !o_valid || i_ready;
    assign o_ready    = (state == IDLE) && out_free;
    assign accept     = i_valid && o_ready;
    assign load_now   = accept && !multi;
    assign load_shift = (state == SHIFT) && (cnt <= 5'd1) && out_free;

    assign sum  = i_a + i_b;
    assign diff = i_a - i_b;

    // One-bit shift step of the working register
    always_comb begin
        step_val = {1'b0, work[DATA_W-1:1]};
        if (shl)
            step_val = {work[DATA_W-2:0], 1'b0};
        else if (sar)
            step_val = {work[DATA_W-1], work[DATA_W-1:1]};
    end

    // Single-cycle result and branch decision
    always_comb begin
        res   = '0;
        taken = 1'b0;
        if (!illegal) begin
            case (i_alu_control)
                4'b0000: res = sum;
                4'b0001: res = diff;
                4'b0010: res = i_a & i_b;
                4'b0011: res = i_a | i_b;
                4'b0100: res = DATA_W'($signed(i_a) < $signed(i_b));
                4'b0101: res = i_a ^ i_b;
                4'b0110: res = ~(i_a | i_b);
                4'b0111: res = i_b;
                4'b1000: res = i_b;
                4'b1001: res = i_b;
                4'b1010: res = DATA_W'(i_a < i_b);
                4'b1011: res = i_a;
                4'b1100: begin
                    res   = diff;
                    taken = (i_a == i_b);
                end
                4'b1101: res = i_b;
                4'b1110: begin
                    res   = diff;
                    taken = (i_a != i_b);
                end
                4'b1111: res = {i_b[15:0], 16'h0000};
                default: res = '0;
            endcase
        end
    end

    // Handshake FSM, iterative shifter and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            work           <= '0;
            shl            <= 1'b0;
            sar            <= 1'b0;
            o_valid        <= 1'b0;
            o_result       <= '0;
            o_branch_taken <= 1'b0;
            o_illegal      <= 1'b0;
        end else begin
            if (o_valid && i_ready)
                o_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && multi) begin
                        work  <= i_b;
                        cnt   <= i_shamt;
                        shl   <= (i_alu_control == 4'b0111);
                        sar   <= (i_alu_control == 4'b1001);
                        state <= SHIFT;
                    end else if (load_now) begin
                        o_result       <= res;
                        o_branch_taken <= taken;
                        o_illegal      <= illegal;
                        o_valid        <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != 5'd0) begin
                        work <= step_val;
                        cnt  <= cnt - 5'd1;
                    end
                    if (load_shift) begin
                        o_result       <= (cnt != 5'd0) ? step_val : work;
                        o_branch_taken <= 1'b0;
                        o_illegal      <= 1'b0;
                        o_valid        <= 1'b1;
                        state          <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef ALU_EXEC_OVF_EN
    logic ovf_q;
    logic ovf_next;

    assign ovf_next =
        (!illegal && i_alu_control == 4'b0000 &&
         i_a[DATA_W-1] == i_b[DATA_W-1] &&
         sum[DATA_W-1] != i_a[DATA_W-1]) ||
        (!illegal && i_alu_control == 4'b0001 &&
         i_a[DATA_W-1] != i_b[DATA_W-1] &&
         diff[DATA_W-1] != i_a[DATA_W-1]);

    // Overflow flag travels with the result it belongs to
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            ovf_q <= 1'b0;
        else if (load_now)
            ovf_q <= ovf_next;
        else if (load_shift)
            ovf_q <= 1'b0;
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage.
// Expected o_ovf follows ALU_EXEC_OVF_EN as defined for the build.
module tb_alu_exec_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_alu_control;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [4:0]  i_shamt;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_branch_taken;
    logic        o_illegal;
    logic        o_ovf;

    int tests;
    int fails;

`ifdef ALU_EXEC_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    alu_exec_stage #(.DATA_W(32)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_alu_control (i_alu_control),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_shamt       (i_shamt),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_result      (o_result),
        .o_branch_taken(o_branch_taken),
        .o_illegal     (o_illegal),
        .o_ovf         (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s);
        i_valid       = 1'b1;
        i_alu_control = c;
        i_a           = a;
        i_b           = b;
        i_shamt       = s;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_alu_control = 4'h0;
        i_a = '0;
        i_b = '0;
        i_shamt = '0;
        step();
        step();
        i_rst_n = 1'b1;
        step();
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid got %b want 0", o_valid);
        end
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got %b want 1", o_ready);
        end
        tests++;
        if ({o_result, o_branch_taken, o_illegal, o_ovf} !== 35'd0) begin
            fails++;
            $display("FAIL reset_outputs got %h/%b/%b/%b want 0",
                     o_result, o_branch_taken, o_illegal, o_ovf);
        end
    endtask

    task automatic test_add_sub();
        i_ready = 1'b1;
        drive(4'b0000, 32'd5, 32'd7, 5'd0);
        step();
        tests++;
        if (o_valid !== 1'b1 || o_result !== 32'd12) begin
            fails++;
            $display("FAIL add got v=%b %h want v=1 0000000c",
                     o_valid, o_result);
        end
        drive(4'b0001, 32'd3, 32'd5, 5'd0);
        step();
        tests++;
        if (o_valid !== 1'b1 || o_result !== 32'hFFFFFFFE) begin
            fails++;
            $display("FAIL sub got v=%b %h want v=1 fffffffe",
                     o_valid, o_result);
        end
        i_valid = 1'b0;
        step();
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_valid got %b want 0", o_valid);
        end
    endtask

    task automatic test_logic();
        logic [3:0]  op [9];
        logic [31:0] va [9];
        logic [31:0] vb [9];
        logic [31:0] ex [9];
        op = '{4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0100,
               4'b1010, 4'b1011, 4'b1101, 4'b1111};
        va = '{32'hF0F00F0F, 32'hF0F00F0F, 32'hF0F00F0F,
               32'hF0F00F0F, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h00400000, 32'h0, 32'h0};
        vb = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
               32'hFF00FF00, 32'h1, 32'h1, 32'h0,
               32'h00400008, 32'h00001234};
        ex = '{32'hF0000F00, 32'hFFF0FF0F, 32'h0FF0F00F,
               32'h000F00F0, 32'h1, 32'h0, 32'h00400000,
               32'h00400008, 32'h12340000};
        i_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(op[i], va[i], vb[i], 5'd0);
            step();
            tests++;
            if (o_valid !== 1'b1 || o_result !== ex[i] ||
                o_branch_taken !== 1'b0) begin
                fails++;
                $display("FAIL logic_op%0d got v=%b %h t=%b want v=1 %h t=0",
                         i, o_valid, o_result, o_branch_taken, ex[i]);
            end
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_shift(input string nm, input logic [3:0] c,
                              input logic [31:0] b, input logic [4:0] s,
                              input logic [31:0] ex);
        int lat;
        logic busy_ok;
        i_ready = 1'b1;
        drive(c, 32'h0, b, s);
        step();
        i_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (o_valid !== 1'b1 && lat < 40) begin
            if (o_ready !== 1'b0)
                busy_ok = 1'b0;
            step();
            lat++;
        end
        tests++;
        if (lat !== int'(s) || !busy_ok) begin
            fails++;
            $display("FAIL %s_latency got %0d busy_ok=%b want %0d",
                     nm, lat, busy_ok, s);
        end
        tests++;
        if (o_valid !== 1'b1 || o_result !== ex) begin
            fails++;
            $display("FAIL %s_result got v=%b %h want v=1 %h",
                     nm, o_valid, o_result, ex);
        end
        step();
    endtask

    task automatic test_branch();
        i_ready = 1'b1;
        drive(4'b1100, 32'd9, 32'd9, 5'd0);
        step();
        tests++;
        if (o_branch_taken !== 1'b1 || o_result !== 32'd0) begin
            fails++;
            $display("FAIL beq_eq got t=%b %h want t=1 0",
                     o_branch_taken, o_result);
        end
        drive(4'b1110, 32'd9, 32'd9, 5'd0);
        step();
        tests++;
        if (o_branch_taken !== 1'b0) begin
            fails++;
            $display("FAIL bne_eq got t=%b want 0", o_branch_taken);
        end
        drive(4'b1110, 32'd9, 32'd3, 5'd0);
        step();
        tests++;
        if (o_branch_taken !== 1'b1 || o_result !== 32'd6) begin
            fails++;
            $display("FAIL bne_ne got t=%b %h want t=1 6",
                     o_branch_taken, o_result);
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        logic [3:0] probe;
        logic exp_ill;
        probe = 4'bzzzz;
        exp_ill = (^probe === 1'bx);
        i_ready = 1'b1;
        drive(4'bzzzz, 32'h0, 32'h0, 5'd0);
        step();
        tests++;
        if (o_valid !== 1'b1 || o_illegal !== exp_ill ||
            o_result !== 32'd0 || o_branch_taken !== 1'b0) begin
            fails++;
            $display("FAIL illegal got v=%b ill=%b %h t=%b want v=1 ill=%b 0 t=0",
                     o_valid, o_illegal, o_result, o_branch_taken, exp_ill);
        end
        drive(4'b0000, 32'd1, 32'd1, 5'd0);
        step();
        tests++;
        if (o_illegal !== 1'b0 || o_result !== 32'd2) begin
            fails++;
            $display("FAIL illegal_clear got ill=%b %h want ill=0 2",
                     o_illegal, o_result);
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        logic hold_ok;
        i_ready = 1'b0;
        drive(4'b0000, 32'd1, 32'd2, 5'd0);
        step();
        drive(4'b0000, 32'd10, 32'd20, 5'd0);
        hold_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== 32'd3)
                hold_ok = 1'b0;
            step();
        end
        tests++;
        if (!hold_ok) begin
            fails++;
            $display("FAIL stall_hold got r=%b v=%b %h want r=0 v=1 3",
                     o_ready, o_valid, o_result);
        end
        i_ready = 1'b1;
        #1;
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_ready got %b want 1", o_ready);
        end
        step();
        tests++;
        if (o_valid !== 1'b1 || o_result !== 32'd30) begin
            fails++;
            $display("FAIL stall_release got v=%b %h want v=1 1e",
                     o_valid, o_result);
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_ovf();
        i_ready = 1'b1;
        drive(4'b0000, 32'h7FFFFFFF, 32'h1, 5'd0);
        step();
        tests++;
        if (o_result !== 32'h80000000 || o_ovf !== OVF_EXP) begin
            fails++;
            $display("FAIL add_ovf got %h ovf=%b want 80000000 ovf=%b",
                     o_result, o_ovf, OVF_EXP);
        end
        drive(4'b0001, 32'h80000000, 32'h1, 5'd0);
        step();
        tests++;
        if (o_result !== 32'h7FFFFFFF || o_ovf !== OVF_EXP) begin
            fails++;
            $display("FAIL sub_ovf got %h ovf=%b want 7fffffff ovf=%b",
                     o_result, o_ovf, OVF_EXP);
        end
        drive(4'b0000, 32'd1, 32'd1, 5'd0);
        step();
        tests++;
        if (o_ovf !== 1'b0) begin
            fails++;
            $display("FAIL no_ovf got %b want 0", o_ovf);
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_shift();
        logic stale;
        i_ready = 1'b1;
        drive(4'b0111, 32'h0, 32'h1, 5'd10);
        step();
        i_valid = 1'b0;
        step();
        step();
        i_rst_n = 1'b0;
        step();
        tests++;
        if (o_valid !== 1'b0 || o_result !== 32'd0 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_shift got v=%b %h r=%b want v=0 0 r=1",
                     o_valid, o_result, o_ready);
        end
        i_rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (o_valid !== 1'b0)
                stale = 1'b1;
        end
        tests++;
        if (stale) begin
            fails++;
            $display("FAIL rst_stale got stale result want none");
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add_sub();
        test_logic();
        test_shift("sra4", 4'b1001, 32'h80000000, 5'd4, 32'hF8000000);
        test_shift("sra0", 4'b1001, 32'h80000000, 5'd0, 32'h80000000);
        test_shift("sll31", 4'b0111, 32'h00000001, 5'd31, 32'h80000000);
        test_shift("srl31", 4'b1000, 32'h80000000, 5'd31, 32'h00000001);
        test_shift("srl3", 4'b1000, 32'hF0000000, 5'd3, 32'h1E000000);
        test_branch();
        test_illegal();
        test_stall();
        test_ovf();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
